// File: rtl/rect_fill_fb.sv
// Single-frame RGB565 framebuffer: clears itself after reset, executes clipped
// rectangle fills one pixel per clock, and serves a registered read port to the LCD.
module rect_fill_fb #(
    parameter int          H_RES       = 240,
    parameter int          V_RES       = 135,
    parameter int          ADR_W       = 15,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_x,
    input  logic [7:0]       cmd_y,
    input  logic [8:0]       cmd_w,
    input  logic [7:0]       cmd_h,
    input  logic [15:0]      cmd_color,
    output logic             busy,
    input  logic [ADR_W-1:0] adr,
    output logic [15:0]      pixel_out
);

    localparam int NPIX = H_RES * V_RES;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_CLIP  = 2'd2;
    localparam logic [1:0] ST_FILL  = 2'd3;

    logic [15:0]      mem [0:NPIX-1];

    logic [1:0]       state_r;
    logic [ADR_W-1:0] clr_adr_r;
    logic [7:0]       cx_r;
    logic [7:0]       cy_r;
    logic [8:0]       cw_r;
    logic [7:0]       ch_r;
    logic [15:0]      color_r;
    logic [9:0]       x_end_r;
    logic [9:0]       y_end_r;
    logic [9:0]       col_r;
    logic [9:0]       row_r;
    logic [ADR_W-1:0] row_base_r;
    logic             cmd_ready_r;
    logic             busy_r;
    logic [15:0]      pixel_r;

    logic             accept_s;
    logic [9:0]       x_sum_s;
    logic [9:0]       y_sum_s;
    logic [9:0]       x_end_s;
    logic [9:0]       y_end_s;
    logic             drop_s;
    logic             row_last_s;
    logic             frame_last_s;
    logic             we_s;
    logic [ADR_W-1:0] wa_s;
    logic [15:0]      wd_s;

    assign accept_s     = cmd_valid & cmd_ready_r & (state_r == ST_IDLE);
    assign x_sum_s      = {2'b00, cx_r} + {1'b0, cw_r};
    assign y_sum_s      = {2'b00, cy_r} + {2'b00, ch_r};
    assign x_end_s      = (x_sum_s > 10'(H_RES)) ? 10'(H_RES) : x_sum_s;
    assign y_end_s      = (y_sum_s > 10'(V_RES)) ? 10'(V_RES) : y_sum_s;
    assign drop_s       = (cw_r == 9'd0) || (ch_r == 8'd0) ||
                          ({2'b00, cx_r} >= 10'(H_RES)) || ({2'b00, cy_r} >= 10'(V_RES));
    assign row_last_s   = (col_r == (x_end_r - 10'd1));
    assign frame_last_s = row_last_s && (row_r == (y_end_r - 10'd1));

    // Write-port source select: clear sweep or rectangle fill
    always_comb begin
        we_s = 1'b0;
        wa_s = '0;
        wd_s = 16'h0000;
        case (state_r)
            ST_CLEAR: begin
                we_s = 1'b1;
                wa_s = clr_adr_r;
                wd_s = CLEAR_COLOR;
            end
            ST_FILL: begin
                we_s = 1'b1;
                wa_s = row_base_r + ADR_W'(col_r);
                wd_s = color_r;
            end
            default: begin
                we_s = 1'b0;
                wa_s = '0;
                wd_s = 16'h0000;
            end
        endcase
    end

    // Control FSM; cmd_ready rises one cycle after returning to IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_CLEAR;
            clr_adr_r   <= '0;
            cx_r        <= 8'd0;
            cy_r        <= 8'd0;
            cw_r        <= 9'd0;
            ch_r        <= 8'd0;
            color_r     <= 16'h0000;
            x_end_r     <= 10'd0;
            y_end_r     <= 10'd0;
            col_r       <= 10'd0;
            row_r       <= 10'd0;
            row_base_r  <= '0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            cmd_ready_r <= (state_r == ST_IDLE) && !accept_s;
            busy_r      <= !((state_r == ST_IDLE) && !accept_s);
            case (state_r)
                ST_CLEAR: begin
                    if (clr_adr_r == ADR_W'(NPIX - 1)) begin
                        clr_adr_r <= '0;
                        state_r   <= ST_IDLE;
                    end else begin
                        clr_adr_r <= clr_adr_r + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        cx_r    <= cmd_x;
                        cy_r    <= cmd_y;
                        cw_r    <= cmd_w;
                        ch_r    <= cmd_h;
                        color_r <= cmd_color;
                        state_r <= ST_CLIP;
                    end
                end
                ST_CLIP: begin
                    x_end_r    <= x_end_s;
                    y_end_r    <= y_end_s;
                    col_r      <= {2'b00, cx_r};
                    row_r      <= {2'b00, cy_r};
                    // constant multiply: folds to shifts/adds
                    row_base_r <= ADR_W'(cy_r) * ADR_W'(H_RES);
                    state_r    <= drop_s ? ST_IDLE : ST_FILL;
                end
                ST_FILL: begin
                    if (frame_last_s) begin
                        state_r <= ST_IDLE;
                    end else if (row_last_s) begin
                        row_base_r <= row_base_r + ADR_W'(H_RES);
                        col_r      <= {2'b00, cx_r};
                        row_r      <= row_r + 10'd1;
                    end else begin
                        col_r <= col_r + 10'd1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                end
            endcase
        end
    end

    // Frame RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[wa_s] <= wd_s;
        end
    end

    // Registered read port; same-cycle write is seen only on the next read
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixel_r <= 16'h0000;
        end else if (adr < ADR_W'(NPIX)) begin
            pixel_r <= mem[adr];
        end else begin
            pixel_r <= 16'h0000;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign pixel_out = pixel_r;

endmodule

// File: tb/tb_rect_fill_fb.sv
// Bench for rect_fill_fb: timeline model of the frame (clear sweep, clipped
// fills, ready/busy occupancy) compared every cycle, plus literal spot checks.
module tb_rect_fill_fb;

    localparam int H  = 240;
    localparam int V  = 135;
    localparam int NP = H * V;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [7:0]  cmd_h;
    logic [15:0] cmd_color;
    logic        busy;
    logic [14:0] adr;
    logic [15:0] pixel_out;

    always #5 clk = ~clk;

    rect_fill_fb dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .busy(busy), .adr(adr), .pixel_out(pixel_out)
    );

    int checks = 0;
    int errors = 0;
    bit adr_rand = 1'b0;

    // Reference model state
    typedef struct { bit v; int a; logic [15:0] c; } wr_t;
    wr_t         wq[$];
    logic [15:0] mem_m [NP];
    bit          known [NP];
    bit          clearing = 1'b1;
    int          clr_idx = 0;
    int          hold = 0;
    bit          exp_ready = 1'b0;
    logic [15:0] exp_pix = 16'h0000;
    bit          exp_known = 1'b1;

    // Model: per clock, read old data, retire the write scheduled for this edge, take a new command
    initial begin
        bit  acc;
        int  x, y, xe, ye;
        wr_t w;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                wq.delete();
                clearing  = 1'b1;
                clr_idx   = 0;
                hold      = 0;
                exp_ready = 1'b0;
                exp_pix   = 16'h0000;
                exp_known = 1'b1;
            end else begin
                acc = cmd_valid && exp_ready;
                if (int'(adr) < NP) begin
                    exp_pix   = mem_m[int'(adr)];
                    exp_known = known[int'(adr)];
                end else begin
                    exp_pix   = 16'h0000;
                    exp_known = 1'b1;
                end
                if (hold > 0) hold--;
                if (clearing) begin
                    mem_m[clr_idx] = 16'h0000;
                    known[clr_idx] = 1'b1;
                    clr_idx++;
                    if (clr_idx == NP) begin
                        clearing = 1'b0;
                        hold     = 1;
                    end
                end else if (wq.size() > 0) begin
                    w = wq.pop_front();
                    if (w.v) begin
                        mem_m[w.a] = w.c;
                        known[w.a] = 1'b1;
                    end
                end
                if (acc) begin
                    x = int'(cmd_x);
                    y = int'(cmd_y);
                    if (cmd_w == 9'd0 || cmd_h == 8'd0 || x >= H || y >= V) begin
                        hold = 2;
                    end else begin
                        xe = (x + int'(cmd_w) > H) ? H : x + int'(cmd_w);
                        ye = (y + int'(cmd_h) > V) ? V : y + int'(cmd_h);
                        wq.push_back('{v: 1'b0, a: 0, c: 16'h0000});
                        for (int r = y; r < ye; r++)
                            for (int c = x; c < xe; c++)
                                wq.push_back('{v: 1'b1, a: r * H + c, c: cmd_color});
                        hold = 2 + (xe - x) * (ye - y);
                    end
                end
                exp_ready = !clearing && (hold == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: compare outputs against the model, then optionally move the read address
    task automatic tick();
        @(negedge clk);
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
        chk("busy", {31'd0, busy}, {31'd0, !exp_ready});
        if (exp_known) chk("pixel_out", {16'd0, pixel_out}, {16'd0, exp_pix});
        if (adr_rand) begin
            if ($urandom_range(0, 7) == 0) adr = 15'($urandom_range(NP, 32767));
            else adr = 15'($urandom_range(0, NP - 1));
        end
    endtask

    task automatic send(input int x, input int y, input int w, input int h,
                        input logic [15:0] c, input bit keep);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = c;
        while (!cmd_ready && n < 40000) begin
            tick();
            n++;
        end
        if (n >= 40000) begin
            errors++;
            $display("FAIL send_timeout: got no cmd_ready required cmd_ready=1");
        end
        tick();
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic low_len(output int cnt);
        cnt = 0;
        while (!cmd_ready && cnt < 40000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic clear_len(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!cmd_ready && cnt < 40000);
    endtask

    task automatic rd(input int a, input logic [15:0] e, input string nm);
        adr = 15'(a);
        tick();
        chk(nm, {16'd0, pixel_out}, {16'd0, e});
    endtask

    initial begin
        int cnt;
        bit keep;
        resetn = 1'b1; cmd_valid = 1'b0; cmd_x = 8'd0; cmd_y = 8'd0; cmd_w = 9'd0;
        cmd_h = 8'd0; cmd_color = 16'h0000; adr = 15'd0;
        #2 resetn = 1'b0;
        repeat (3) tick();
        #2 resetn = 1'b1;

        // Power-up clear
        adr_rand = 1'b1;
        clear_len(cnt);
        chk("clear_ready_cycle", cnt, 32401);
        rd(0, 16'h0000, "clear_adr0");
        rd(32399, 16'h0000, "clear_adr_last");
        rd(12345, 16'h0000, "clear_adr_mid");
        rd(32400, 16'h0000, "out_of_range");

        // Single pixel
        send(0, 0, 1, 1, 16'hF800, 1'b0);
        low_len(cnt);
        chk("px1_ready_low", cnt, 3);
        rd(0, 16'hF800, "px1_adr0");
        rd(1, 16'h0000, "px1_adr1");

        // Clipped corner rectangle
        send(230, 130, 20, 10, 16'h07E0, 1'b0);
        low_len(cnt);
        chk("corner_busy_len", cnt, 52);
        rd(32399, 16'h07E0, "corner_last");
        rd(31430, 16'h07E0, "corner_first");
        rd(31429, 16'h0000, "corner_left_out");

        // Dropped commands
        send(5, 5, 0, 3, 16'hFFFF, 1'b0);
        low_len(cnt);
        chk("drop_w0", cnt, 2);
        send(240, 5, 3, 3, 16'hFFFF, 1'b0);
        low_len(cnt);
        chk("drop_x240", cnt, 2);
        send(5, 135, 3, 3, 16'hFFFF, 1'b0);
        low_len(cnt);
        chk("drop_y135", cnt, 2);
        rd(5 * H + 5, 16'h0000, "drop_no_write");

        // Read/write collision at adr 481
        adr_rand = 1'b0;
        adr = 15'd481;
        send(1, 2, 1, 1, 16'h001F, 1'b0);
        tick();
        tick();
        chk("collision_old", {16'd0, pixel_out}, 32'h0000);
        tick();
        chk("collision_new", {16'd0, pixel_out}, 32'h001F);
        low_len(cnt);

        // Random commands, some back-to-back with cmd_valid held
        adr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            keep = (i < 39) && ($urandom_range(0, 1) == 1);
            send($urandom_range(0, 245), $urandom_range(0, 140), $urandom_range(0, 30),
                 $urandom_range(0, 20), 16'($urandom), keep);
        end
        low_len(cnt);

        // Reset in the middle of a full-frame fill
        send(0, 0, 240, 135, 16'hABCD, 1'b0);
        repeat (3000) tick();
        #2 resetn = 1'b0;
        #1;
        chk("abort_pixel", {16'd0, pixel_out}, 32'h0000);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        tick();
        #2 resetn = 1'b1;
        clear_len(cnt);
        chk("reclear_ready_cycle", cnt, 32401);
        repeat (1500) tick();
        rd(0, 16'h0000, "reclear_adr0");
        rd(100 * H + 7, 16'h0000, "reclear_mid");
        rd(32399, 16'h0000, "reclear_last");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
